// File: rtl/count_ctrl_pkg.sv
// Shared types and defaults for the count_ctrl block.
// FSM state encoding and the default counter/limit width.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/cnt_core.sv
// WIDTH-bit count register with synchronous clear and increment.
// clr has priority over inc; rstn clears the register asynchronously.
module cnt_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Next count: clear wins, otherwise step by one when asked, else hold.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc) begin
      count_next = count_reg + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: start/run/done counter controller.
// A start in IDLE captures limit and counts from 0 up to it while en is
// high, then parks in DONE until ack; abort cancels a run at any time.
// Optional feature macro COUNT_CTRL_RELOAD_EN adds input reload: at the
// terminal count with reload high the run restarts from 0 and done pulses
// for one cycle instead of waiting for ack.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             en,
  input  logic             abort,
  input  logic             ack,
`ifdef COUNT_CTRL_RELOAD_EN
  input  logic             reload,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] limit_reg;
  logic [WIDTH-1:0] limit_next;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             at_limit;

  assign at_limit = (count == limit_reg);

  cnt_core #(
    .WIDTH (WIDTH)
  ) u_cnt_core (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (count)
  );

`ifdef COUNT_CTRL_RELOAD_EN
  logic pulse_reg;
  logic pulse_next;
`endif

  // Next-state, limit capture and counter control; abort outranks everything.
  always_comb begin
    state_next = state_reg;
    limit_next = limit_reg;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
`ifdef COUNT_CTRL_RELOAD_EN
    pulse_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        // abort in IDLE does nothing except suppress a coincident start
        if (start && !abort) begin
          limit_next = limit;
          cnt_clr    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          cnt_clr    = 1'b1;
          state_next = IDLE;
        end else if (at_limit) begin
`ifdef COUNT_CTRL_RELOAD_EN
          if (reload) begin
            cnt_clr    = 1'b1;
            pulse_next = 1'b1;
          end else begin
            state_next = DONE;
          end
`else
          state_next = DONE;
`endif
        end else if (en) begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        if (abort || ack) begin
          cnt_clr    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_clr    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // State and captured limit registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      limit_reg <= '0;
    end else begin
      state_reg <= state_next;
      limit_reg <= limit_next;
    end
  end

`ifdef COUNT_CTRL_RELOAD_EN
  // One-cycle done pulse following each reload wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pulse_reg <= 1'b0;
    end else begin
      pulse_reg <= pulse_next;
    end
  end

  assign done = (state_reg == DONE) || pulse_reg;
`else
  assign done = (state_reg == DONE);
`endif

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: each step pushes the expected
// {busy, done, count} to a scoreboard, clocks once, and pops/compares.
module tb_count_ctrl;

  localparam int WIDTH = 4;

  typedef struct {
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] count;
    string            tag;
  } exp_t;

  logic             clk;
  logic             rstn;
  logic             start;
  logic [WIDTH-1:0] limit;
  logic             en;
  logic             abort;
  logic             ack;
  logic             reload;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;

  exp_t sb[$];
  int   checks;
  int   failures;

  count_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .limit  (limit),
    .en     (en),
    .abort  (abort),
    .ack    (ack),
`ifdef COUNT_CTRL_RELOAD_EN
    .reload (reload),
`endif
    .busy   (busy),
    .done   (done),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic push_exp(input logic b, input logic d, input int c, input string tag);
    exp_t e;
    e.busy  = b;
    e.done  = d;
    e.count = c[WIDTH-1:0];
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert ({busy, done, count} === {e.busy, e.done, e.count})
    else begin
      failures++;
      $error("FAIL %s got busy=%b done=%b count=%0d exp busy=%b done=%b count=%0d",
             e.tag, busy, done, count, e.busy, e.done, e.count);
    end
    $display("step %-12s busy=%b done=%b count=%0d", e.tag, busy, done, count);
  endtask

  // Drive one cycle of inputs, clock once, compare output after the edge.
  task automatic cyc(input logic st, input logic en_i, input logic ab, input logic ak,
                     input logic b, input logic d, input int c, input string tag);
    start = st;
    en    = en_i;
    abort = ab;
    ack   = ak;
    push_exp(b, d, c, tag);
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn   = 1'b0;
    start  = 1'b0;
    en     = 1'b0;
    abort  = 1'b0;
    ack    = 1'b0;
    reload = 1'b0;
    limit  = 4'd7;
    #12;
    push_exp(0, 0, 0, "reset");
    check_now();
    rstn = 1'b1;
    cyc(0, 1, 0, 0, 0, 0, 0, "idle");

    // basic run limit=5 with ignored start requests while busy
    limit = 4'd5;
    cyc(1, 1, 0, 0, 1, 0, 0, "basic_start");
    limit = 4'd2;
    for (int i = 1; i <= 5; i++) cyc(i[0], 1, 0, 0, 1, 0, i, "basic_cnt");
    cyc(1, 1, 0, 0, 1, 1, 5, "basic_done");
    cyc(0, 0, 0, 0, 1, 1, 5, "done_hold");
    cyc(0, 0, 0, 1, 0, 0, 0, "basic_ack");

    // en low holds count; terminal transition ignores en
    limit = 4'd3;
    cyc(1, 0, 0, 0, 1, 0, 0, "hold_start");
    cyc(0, 1, 0, 0, 1, 0, 1, "hold_cnt");
    cyc(0, 0, 0, 0, 1, 0, 1, "hold_en0");
    cyc(0, 0, 0, 0, 1, 0, 1, "hold_en0");
    cyc(0, 1, 0, 0, 1, 0, 2, "hold_cnt");
    cyc(0, 1, 0, 0, 1, 0, 3, "hold_cnt");
    cyc(0, 0, 0, 0, 1, 1, 3, "hold_done");
    cyc(1, 0, 0, 1, 0, 0, 0, "ack_start_dn");
    cyc(0, 0, 0, 0, 0, 0, 0, "no_queue");
    limit = 4'd1;
    cyc(1, 1, 0, 1, 1, 0, 0, "ack_start_id");
    cyc(0, 1, 0, 0, 1, 0, 1, "as_cnt");
    cyc(0, 1, 0, 1, 1, 1, 1, "as_done");
    cyc(0, 0, 0, 1, 0, 0, 0, "as_ack");

    // abort mid-run
    limit = 4'd9;
    cyc(1, 1, 0, 0, 1, 0, 0, "abort_start");
    cyc(0, 1, 0, 0, 1, 0, 1, "abort_cnt");
    cyc(0, 1, 0, 0, 1, 0, 2, "abort_cnt");
    cyc(0, 1, 1, 0, 0, 0, 0, "abort_run");
    cyc(0, 1, 0, 0, 0, 0, 0, "abort_idle");
    cyc(1, 1, 1, 0, 0, 0, 0, "abort_blocks");

    // limit=0: done after edge 1; abort beats terminal and ack
    limit = 4'd0;
    cyc(1, 0, 0, 0, 1, 0, 0, "lim0_start");
    cyc(0, 0, 1, 0, 0, 0, 0, "abort_term");
    cyc(1, 0, 0, 0, 1, 0, 0, "lim0_start");
    cyc(0, 0, 0, 0, 1, 1, 0, "lim0_done");
    cyc(0, 0, 1, 1, 0, 0, 0, "abort_ack");

    // limit=15: no wrap at the all-ones count
    limit = 4'd15;
    cyc(1, 1, 0, 0, 1, 0, 0, "max_start");
    for (int i = 1; i <= 15; i++) cyc(0, 1, 0, 0, 1, 0, i, "max_cnt");
    cyc(0, 1, 0, 0, 1, 1, 15, "max_done");
    cyc(0, 1, 0, 0, 1, 1, 15, "max_nowrap");
    cyc(0, 0, 0, 1, 0, 0, 0, "max_ack");

    // asynchronous reset mid-run
    limit = 4'd9;
    cyc(1, 1, 0, 0, 1, 0, 0, "rst_start");
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 0, 1, 0, i, "rst_cnt");
    rstn = 1'b0;
    #1;
    push_exp(0, 0, 0, "async_rst");
    check_now();
    cyc(1, 1, 0, 0, 0, 0, 0, "in_reset");
    rstn  = 1'b1;
    limit = 4'd1;
    cyc(1, 1, 0, 0, 1, 0, 0, "post_rst");
    cyc(0, 1, 0, 0, 1, 0, 1, "post_cnt");
    cyc(0, 1, 0, 0, 1, 1, 1, "post_done");
    cyc(0, 0, 0, 1, 0, 0, 0, "post_ack");

`ifdef COUNT_CTRL_RELOAD_EN
    // reload: wrap to 0 with a one-cycle done pulse, then normal DONE
    limit  = 4'd2;
    reload = 1'b1;
    cyc(1, 1, 0, 0, 1, 0, 0, "rl_start");
    cyc(0, 1, 0, 0, 1, 0, 1, "rl_cnt");
    cyc(0, 1, 0, 0, 1, 0, 2, "rl_cnt");
    cyc(0, 1, 0, 0, 1, 1, 0, "rl_wrap");
    cyc(0, 1, 0, 0, 1, 0, 1, "rl_cnt");
    cyc(0, 1, 0, 0, 1, 0, 2, "rl_cnt");
    cyc(0, 1, 0, 0, 1, 1, 0, "rl_wrap");
    reload = 1'b0;
    cyc(0, 1, 0, 0, 1, 0, 1, "rl_cnt");
    cyc(0, 1, 0, 0, 1, 0, 2, "rl_cnt");
    cyc(0, 1, 0, 0, 1, 1, 2, "rl_done");
    cyc(0, 1, 0, 0, 1, 1, 2, "rl_hold");
    cyc(0, 0, 0, 1, 0, 0, 0, "rl_ack");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter and limit width in bits.
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its posedge.
REQ-003 Port rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port start  input  1  SHALL request a count run; sampled only in IDLE.
REQ-005 Port limit  input  WIDTH  SHALL give the terminal count, captured on the accepted start.
REQ-006 Port en  input  1  SHALL allow counting in RUN; low holds count.
REQ-007 Port abort  input  1  SHALL cancel a run in RUN or DONE.
REQ-008 Port ack  input  1  SHALL acknowledge done.
REQ-009 Port busy  output  1  SHALL be high in RUN and DONE.
REQ-010 Port done  output  1  SHALL be high exactly while in DONE.
REQ-011 Port count  output  WIDTH  SHALL present the current count value.

Function
REQ-012 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 IDLE, start=1: next edge SHALL set limit_q<=limit, count<=0, state<=RUN.
REQ-014 start outside IDLE SHALL be ignored, with no queuing.
REQ-015 RUN, en=1, count!=limit_q: count SHALL increment by 1 per edge.
REQ-016 RUN, count==limit_q: next edge SHALL move to DONE, independent of en, with count held.
REQ-017 RUN, en=0, count!=limit_q: count and state SHALL hold.
REQ-018 Latency with en held high SHALL be: done high after edge limit_q+1, counting the start-accept edge as edge 0.
REQ-019 limit=0 SHALL give RUN for one edge, then DONE.
REQ-020 limit=2^WIDTH-1 SHALL reach the all-ones count with no wrap; count SHALL never wrap in base mode.
REQ-021 DONE SHALL hold done=1 and count until ack=1; the next edge SHALL then clear count to 0 and go to IDLE.
REQ-022 abort=1 in RUN or DONE SHALL clear count to 0 and go to IDLE on the next edge, with no done pulse.
REQ-023 abort SHALL take priority over the terminal check and over ack.
REQ-024 abort in IDLE SHALL have no effect, and SHALL block a simultaneous start.
REQ-025 Once in IDLE, ack and start in the same cycle SHALL be treated as an ordinary start.

Reset
REQ-026 rstn low SHALL immediately force state=IDLE, count=0, limit_q=0, busy=0, done=0, without waiting for a clock edge.
REQ-027 Reset mid-run SHALL discard the run with no done.
REQ-028 After rstn rises, the first accepted start SHALL be on the first posedge with start=1.

Configuration
REQ-029 Macro COUNT_CTRL_RELOAD_EN, when defined, SHALL add port reload (input, 1 bit).
REQ-030 With the macro, RUN with count==limit_q and reload=1 SHALL stay in RUN, set count<=0, and assert done for exactly one cycle with no ack required.
REQ-031 With the macro, the run SHALL repeat until reload=0 at terminal (normal DONE) or abort.
REQ-032 Without the macro, port reload SHALL be absent and behaviour SHALL be exactly REQ-012..REQ-025.

Structure
REQ-033 Package count_ctrl_pkg SHALL hold the state typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-034 Sub-module cnt_core SHALL implement the WIDTH-bit register with clr, inc and async active-low reset.
REQ-035 count_ctrl SHALL hold the FSM and limit_q, and SHALL drive cnt_core clr/inc.

Verification
REQ-036 Basic run: rstn released, limit=5, en=1, start pulse -> count 0..5, done=1 at edge 6 with count=5; ack -> IDLE, count=0.
REQ-037 Hold: limit=3, en low for 2 cycles mid-run -> count holds; done delayed by 2 edges.
REQ-038 Abort: abort at count=2 with limit=9 -> IDLE next edge, count=0, done never high.
REQ-039 Reset mid-run: rstn low at count=4 -> count=0 and busy=0 before the next edge.
REQ-040 Boundaries: limit=0 -> done after edge 1; limit=15 -> count reaches 15 with no wrap; start while busy ignored.
REQ-041 Reload (macro on): limit=2, reload=1 -> count 0,1,2,0,1,2 with a one-cycle done pulse per wrap; reload=0 -> DONE held.
